// File: rtl/riscv_crypto_sha512_msg_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : riscv_crypto_sha512_msg_sched
// Brief    : SHA-512 message-schedule expander. Accepts 16 x 64-bit words
//            and streams W[0..79] over a valid/ready handshake. It uses a
//            16-entry circular buffer and computes sig0/sig1 internally.
// Options  : RISCV_CRYPTO_SCHED_SHA256_EN adds op_sha256 and the SHA-256
//            schedule (32-bit words, W[0..63]).
// Revision : 1.0 - initial release
// ============================================================================
module riscv_crypto_sha512_msg_sched #(
    parameter int XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_word,
`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
    input  logic            op_sha256,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_word,
    output logic [6:0]      out_idx,
    output logic            done
);

    generate
        if (XLEN != 64) begin : g_xlen_check
            $error("riscv_crypto_sha512_msg_sched: only XLEN=64 is supported");
        end
    endgenerate

    localparam logic [1:0] c_ST_LOAD = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    function automatic logic [63:0] f_sig0_512(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] f_sig1_512(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
    function automatic logic [31:0] f_sig0_256(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sig1_256(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
`endif

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_cnt;
    logic [63:0]     r_buf [16];
    logic [63:0]     r_out_word;
    logic [6:0]      r_out_idx;

    logic            w_in_fire;
    logic            w_out_fire;
    logic [6:0]      w_last_idx;
    logic [63:0]     w_in_data;
    logic [6:0]      w_nidx;
    logic [3:0]      w_i2;
    logic [3:0]      w_i7;
    logic [3:0]      w_i15;
    logic [3:0]      w_i16;
    logic [63:0]     w_calc;
    logic [63:0]     w_next_word;
    logic            w_advance;
    logic            w_buf_we;
    logic [3:0]      w_buf_addr;
    logic [63:0]     w_buf_data;

    assign in_ready   = (r_state == c_ST_LOAD);
    assign out_valid  = (r_state == c_ST_RUN);
    assign done       = (r_state == c_ST_DONE);
    assign out_word   = r_out_word;
    assign out_idx    = r_out_idx;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Ring-buffer taps for W[t+1]: t-1, t-6, t-14 and t-15 (== t+1 mod 16).
    assign w_nidx = r_out_idx + 7'd1;
    assign w_i2   = r_out_idx[3:0] - 4'd1;
    assign w_i7   = r_out_idx[3:0] - 4'd6;
    assign w_i15  = r_out_idx[3:0] + 4'd2;
    assign w_i16  = w_nidx[3:0];

`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
    logic r_sha256;
    logic w_mode_in;

    // Mode is latched on the first word of a block and held until the next one.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_sha256 <= 1'b0;
        end else if (!clear && w_in_fire && (r_cnt == 4'd0)) begin
            r_sha256 <= op_sha256;
        end
    end

    assign w_mode_in  = (r_cnt == 4'd0) ? op_sha256 : r_sha256;
    assign w_in_data  = w_mode_in ? {32'h0, in_word[31:0]} : in_word;
    assign w_last_idx = r_sha256 ? 7'd63 : 7'd79;

    // Expansion sum in whichever width the current block uses.
    always_comb begin
        w_calc = f_sig1_512(r_buf[w_i2]) + r_buf[w_i7]
               + f_sig0_512(r_buf[w_i15]) + r_buf[w_i16];
        if (r_sha256) begin
            w_calc = {32'h0, f_sig1_256(r_buf[w_i2][31:0]) + r_buf[w_i7][31:0]
                           + f_sig0_256(r_buf[w_i15][31:0]) + r_buf[w_i16][31:0]};
        end
    end
`else
    assign w_in_data  = in_word;
    assign w_last_idx = 7'd79;

    // Expansion sum, carries beyond bit 63 discarded.
    always_comb begin
        w_calc = f_sig1_512(r_buf[w_i2]) + r_buf[w_i7]
               + f_sig0_512(r_buf[w_i15]) + r_buf[w_i16];
    end
`endif

    // First 16 words come straight from the buffer; later ones are computed.
    assign w_next_word = (w_nidx < 7'd16) ? r_buf[w_i16] : w_calc;
    assign w_advance   = (r_state == c_ST_RUN) && w_out_fire && (r_out_idx != w_last_idx);

    // Buffer write port: loaded words, then each newly expanded word.
    always_comb begin
        w_buf_we   = 1'b0;
        w_buf_addr = r_cnt;
        w_buf_data = w_in_data;
        if (!g_reset && !clear) begin
            if ((r_state == c_ST_LOAD) && w_in_fire) begin
                w_buf_we = 1'b1;
            end else if (w_advance && (w_nidx >= 7'd16)) begin
                w_buf_we   = 1'b1;
                w_buf_addr = w_i16;
                w_buf_data = w_calc;
            end
        end
    end

    // Buffer storage has no reset; a new block overwrites every entry.
    always_ff @(posedge g_clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_addr] <= w_buf_data;
        end
    end

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear wins over any coincident handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_LOAD: if (w_in_fire && (r_cnt == 4'd15)) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_out_fire && (r_out_idx == w_last_idx)) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_LOAD;
            default:   w_state_nxt = c_ST_LOAD;
        endcase
        if (clear) begin
            w_state_nxt = c_ST_LOAD;
        end
    end

    // Load counter and registered output word/index.
    always_ff @(posedge g_clk) begin
        if (g_reset || clear) begin
            r_cnt      <= 4'd0;
            r_out_word <= 64'h0;
            r_out_idx  <= 7'd0;
        end else begin
            if ((r_state == c_ST_LOAD) && w_in_fire) begin
                // Counter wraps to 0 on the 16th word, ready for the next block.
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_out_word <= r_buf[0];
                    r_out_idx  <= 7'd0;
                end
            end
            if (w_advance) begin
                r_out_word <= w_next_word;
                r_out_idx  <= w_nidx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_crypto_sha512_msg_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_riscv_crypto_sha512_msg_sched
// Brief    : Directed self-checking bench for the SHA-512 schedule expander.
//            Build with RISCV_CRYPTO_SCHED_SHA256_EN to exercise SHA-256 mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_crypto_sha512_msg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_word;
    logic [6:0]  out_idx;
    logic        done;
`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
    logic        op_sha256;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] blk   [16];
    logic [63:0] model [80];
    logic [63:0] got   [80];

    always #5 clk = ~clk;

    riscv_crypto_sha512_msg_sched #(.XLEN(64)) dut (
        .g_clk     (clk),
        .g_reset   (rst),
        .clear     (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
        .op_sha256 (op_sha256),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Golden schedule written directly from the recurrence over a flat array.
    task automatic build_model(input bit sha);
        logic [31:0] a;
        for (int t = 0; t < 16; t++) model[t] = sha ? {32'h0, blk[t][31:0]} : blk[t];
        for (int t = 16; t < 80; t++) begin
            if (sha) begin
                a = (ror32(model[t-2][31:0], 17) ^ ror32(model[t-2][31:0], 19) ^ (model[t-2][31:0] >> 10))
                  + model[t-7][31:0]
                  + (ror32(model[t-15][31:0], 7) ^ ror32(model[t-15][31:0], 18) ^ (model[t-15][31:0] >> 3))
                  + model[t-16][31:0];
                model[t] = {32'h0, a};
            end else begin
                model[t] = (ror64(model[t-2], 19) ^ ror64(model[t-2], 61) ^ (model[t-2] >> 6))
                         + model[t-7]
                         + (ror64(model[t-15], 1) ^ ror64(model[t-15], 8) ^ (model[t-15] >> 7))
                         + model[t-16];
            end
        end
    endtask

    task automatic set_abc512();
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = 64'h6162638000000000;
        blk[15] = 64'h18;
    endtask

    task automatic load(input int n, input bit sha);
        for (int i = 0; i < n; i++) begin
            check_val("ld_in_ready", 64'(in_ready), 64'd1);
            check_val("ld_out_valid", 64'(out_valid), 64'd0);
            in_valid = 1'b1;
            in_word  = blk[i];
`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
            op_sha256 = (i == 0) ? sha : ~sha;
`endif
            tick();
        end
        in_valid = 1'b0;
        in_word  = 64'h0;
    endtask

    // Consume words; stop_at presents that index and returns without taking it.
    task automatic drain(input int last, input bit stall, input int stop_at);
        int e   = 0;
        int cyc = 0;
        while ((e <= last) && (e != stop_at) && (cyc < 400)) begin
            out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            check_val("out_valid", 64'(out_valid), 64'd1);
            check_val("out_idx", 64'(out_idx), 64'(e));
            check_val($sformatf("w%0d", e), out_word, model[e]);
            got[e] = out_word;
            tick();
            if (out_ready) e++;
            cyc++;
        end
        out_ready = 1'b0;
        if (e == stop_at) return;
        check_val("run_cycles", 64'(cyc), stall ? 64'(2 * (last + 1) - 1) : 64'(last + 1));
        check_val("done_pulse", 64'(done), 64'd1);
        check_val("done_out_valid", 64'(out_valid), 64'd0);
        check_val("done_in_ready", 64'(in_ready), 64'd0);
        tick();
        check_val("post_done", 64'(done), 64'd0);
        check_val("post_in_ready", 64'(in_ready), 64'd1);
        check_val("post_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = 64'h0;
`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
        op_sha256 = 1'b0;
`endif
        tick(); tick(); tick();
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_word", out_word, 64'h0);
        check_val("rst_out_idx", 64'(out_idx), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // "abc" block, full rate
        set_abc512(); build_model(1'b0);
        load(16, 1'b0); drain(79, 1'b0, -1);
        check_val("abc_w0", got[0], 64'h6162638000000000);
        check_val("abc_w15", got[15], 64'h18);
        check_val("abc_w16", got[16], 64'h6162638000000000);
        check_val("abc_w17", got[17], 64'h00030000000000C0);

        // Same block with out_ready toggling
        load(16, 1'b0); drain(79, 1'b1, -1);
        check_val("stall_w17", got[17], 64'h00030000000000C0);

        // All-ones block: carry wrap in the adder chain
        for (int i = 0; i < 16; i++) blk[i] = 64'hFFFFFFFFFFFFFFFF;
        build_model(1'b0);
        load(16, 1'b0); drain(79, 1'b0, -1);
        check_val("ones_w16", got[16], 64'h05FFFFFFFFFFFFFC);

        // Clear after 9 beats, with a coincident beat that must be dropped
        for (int i = 0; i < 16; i++) blk[i] = 64'hA5A5000000000000 | 64'(i);
        load(9, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_word = 64'hDEADBEEFDEADBEEF;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check_val("clr_in_ready", 64'(in_ready), 64'd1);
        check_val("clr_out_valid", 64'(out_valid), 64'd0);
        check_val("clr_done", 64'(done), 64'd0);
        set_abc512(); build_model(1'b0);
        load(16, 1'b0); drain(79, 1'b0, -1);
        check_val("clr_abc_w17", got[17], 64'h00030000000000C0);

        // Reset while presenting idx 40
        load(16, 1'b0); drain(79, 1'b0, 40);
        check_val("pre_rst_idx", 64'(out_idx), 64'd40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_out_idx", 64'(out_idx), 64'd0);
        check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_val("mid_rst_done", 64'(done), 64'd0);

        // Clear in the middle of a run
        for (int i = 0; i < 16; i++) blk[i] = {32'h01234567 + 32'(i), 32'h89ABCDEF - 32'(i)};
        build_model(1'b0);
        load(16, 1'b0); drain(79, 1'b0, 5);
        clr = 1'b1; out_ready = 1'b1;
        tick();
        clr = 1'b0; out_ready = 1'b0;
        check_val("run_clr_out_valid", 64'(out_valid), 64'd0);
        check_val("run_clr_out_idx", 64'(out_idx), 64'd0);
        check_val("run_clr_in_ready", 64'(in_ready), 64'd1);

        // Patterned block after reset/clear
        load(16, 1'b0); drain(79, 1'b0, -1);

`ifdef RISCV_CRYPTO_SCHED_SHA256_EN
        // SHA-256 "abc"; upper halves carry junk that must be discarded
        for (int i = 0; i < 16; i++) blk[i] = 64'hDEADBEEF00000000;
        blk[0]  = 64'hFFFFFFFF61626380;
        blk[15] = 64'h1234567800000018;
        build_model(1'b1);
        load(16, 1'b1); drain(63, 1'b0, -1);
        check_val("s256_w0", got[0], 64'h61626380);
        check_val("s256_w16", got[16], 64'h61626380);
        check_val("s256_w17", got[17], 64'h000F0000);

        // Mode is re-sampled: a SHA-512 block follows
        set_abc512(); build_model(1'b0);
        load(16, 1'b0); drain(79, 1'b0, -1);
        check_val("after256_w17", got[17], 64'h00030000000000C0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
